ccff_bitstream_loader: RTL and testbench

//  Initiator end of the fabric configuration chain: accepts bitstream bytes on a valid/ready stream
//  and drives them serially into the chain (ccff_head, gated prog_clk). Captures ccff_tail as the

---
 rtl/ccff_pkg.sv | 17 +
 rtl/ccff_clk_div.sv | 35 +++
 rtl/ccff_bitstream_loader.sv | 188 ++++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared constants for the configuration-chain loader and its readback/debug tooling.
package ccff_pkg;

    // Default geometry of the fabric configuration chain
    localparam int unsigned DefaultChainLen = 4096;
    localparam int unsigned DefaultDiv      = 4;

    // Loader FSM state encoding (kept as plain constants so tooling can decode a state dump)
    typedef logic [2:0] ccff_state_t;

    localparam ccff_state_t StIdle     = 3'd0;
    localparam ccff_state_t StWaitByte = 3'd1;
    localparam ccff_state_t StShiftLo  = 3'd2;
    localparam ccff_state_t StShiftHi  = 3'd3;
    localparam ccff_state_t StDone     = 3'd4;

endpackage

// File: rtl/ccff_clk_div.sv
// Phase timer for the configuration shift clock: while enabled, flags the last clk cycle of
// every DIV-cycle half-period. It does not drive prog_clk itself.
module ccff_clk_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic phase_end_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count up while enabled, restart at each phase boundary or when idle
    always_comb begin
        phase_end_o = en_i && (cnt_q == LastCnt);
        cnt_d       = cnt_q + 1'b1;
        if (!en_i || phase_end_o) begin
            cnt_d = '0;
        end
    end

    // Phase counter state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Initiator end of the fabric configuration chain: takes bitstream bytes on a valid/ready
// stream, shifts them MSB-first into ccff_head under a divided prog_clk, captures ccff_tail
// for readback and, in verify mode, counts readback bits that differ from the incoming stream.
module ccff_bitstream_loader
    import ccff_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DefaultChainLen,
    parameter int unsigned DIV       = DefaultDiv,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             verify,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             ccff_head,
    input  logic             ccff_tail,
    output logic             prog_clk,
    output logic             set_cfg,
    output logic [7:0]       tail_byte,
    output logic             tail_valid,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam logic [CNT_W-1:0] ChainLenW = CNT_W'(CHAIN_LEN);

    ccff_state_t      state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bits_left_q, bits_left_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             verify_q, verify_d;
    logic [7:0]       tail_sh_q, tail_sh_d;
    logic [2:0]       tail_cnt_q, tail_cnt_d;
    logic [7:0]       tail_byte_q, tail_byte_d;
    logic             tail_valid_q, tail_valid_d;
    logic             done_q, done_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             prog_clk_q, prog_clk_d;
    logic             shifting;
    logic             phase_end;

    assign shifting = (state_q == StShiftLo) || (state_q == StShiftHi);

    ccff_clk_div #(
        .DIV (DIV)
    ) u_clk_div (
        .clk_i       (clk),
        .reset_i     (reset),
        .en_i        (shifting),
        .phase_end_o (phase_end)
    );

    // Load sequencing, tail capture and verify bookkeeping
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bits_left_d  = bits_left_q;
        bit_cnt_d    = bit_cnt_q;
        verify_d     = verify_q;
        tail_sh_d    = tail_sh_q;
        tail_cnt_d   = tail_cnt_q;
        tail_byte_d  = tail_byte_q;
        tail_valid_d = 1'b0;
        done_d       = done_q;
        mismatch_d   = mismatch_q;
        mis_cnt_d    = mis_cnt_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StWaitByte;
                    done_d     = 1'b0;
                    mismatch_d = 1'b0;
                    mis_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    tail_sh_d  = '0;
                    tail_cnt_d = '0;
                    verify_d   = verify;
                end
            end
            StWaitByte: begin
                if (byte_valid) begin
                    shreg_d     = byte_in;
                    bits_left_d = 4'd8;
                    state_d     = StShiftLo;
                end
            end
            StShiftLo: begin
                // Tail is sampled just before the rising prog_clk edge that shifts the chain
                if (phase_end) begin
                    tail_sh_d  = {tail_sh_q[6:0], ccff_tail};
                    tail_cnt_d = tail_cnt_q + 3'd1;
                    if (tail_cnt_q == 3'd7) begin
                        tail_byte_d  = {tail_sh_q[6:0], ccff_tail};
                        tail_valid_d = 1'b1;
                    end
                    if (verify_q && (ccff_tail != shreg_q[7])) begin
                        mismatch_d = 1'b1;
                        if (mis_cnt_q != '1) begin
                            mis_cnt_d = mis_cnt_q + 1'b1;
                        end
                    end
                    state_d = StShiftHi;
                end
            end
            StShiftHi: begin
                if (phase_end) begin
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    shreg_d     = {shreg_q[6:0], 1'b0};
                    bits_left_d = bits_left_q - 4'd1;
                    if (bit_cnt_d == ChainLenW) begin
                        state_d = StDone;
                    end else if (bits_left_d == 4'd0) begin
                        state_d = StWaitByte;
                    end else begin
                        state_d = StShiftLo;
                    end
                end
            end
            StDone: begin
                done_d = 1'b1;
                // Left-align a partial readback group; low bits fill with zeros
                if (tail_cnt_q != 3'd0) begin
                    tail_byte_d  = tail_sh_q << (4'd8 - {1'b0, tail_cnt_q});
                    tail_valid_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        prog_clk_d = (state_d == StShiftHi);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            bits_left_q  <= '0;
            bit_cnt_q    <= '0;
            verify_q     <= 1'b0;
            tail_sh_q    <= '0;
            tail_cnt_q   <= '0;
            tail_byte_q  <= '0;
            tail_valid_q <= 1'b0;
            done_q       <= 1'b0;
            mismatch_q   <= 1'b0;
            mis_cnt_q    <= '0;
            prog_clk_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bits_left_q  <= bits_left_d;
            bit_cnt_q    <= bit_cnt_d;
            verify_q     <= verify_d;
            tail_sh_q    <= tail_sh_d;
            tail_cnt_q   <= tail_cnt_d;
            tail_byte_q  <= tail_byte_d;
            tail_valid_q <= tail_valid_d;
            done_q       <= done_d;
            mismatch_q   <= mismatch_d;
            mis_cnt_q    <= mis_cnt_d;
            prog_clk_q   <= prog_clk_d;
        end
    end

    // Head bit holds across both prog_clk phases so it is stable around the rising edge
    assign ccff_head    = shifting && shreg_q[7];
    assign prog_clk     = prog_clk_q;
    assign set_cfg      = 1'b0;
    assign byte_ready   = (state_q == StWaitByte);
    assign busy         = (state_q != StIdle);
    assign tail_byte    = tail_byte_q;
    assign tail_valid   = tail_valid_q;
    assign done         = done_q;
    assign mismatch     = mismatch_q;
    assign mismatch_cnt = mis_cnt_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for the configuration-chain loader: instance 0 drives a 16-flop chain at DIV=1,
// instance 1 a 12-flop chain at DIV=2. Each chain is modelled as a shift register on prog_clk.
module tb_ccff_bitstream_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start [2];
    logic       verify [2];
    logic [7:0] byte_in [2];
    logic       byte_valid [2];
    logic       byte_ready [2];
    logic       ccff_head [2];
    logic       ccff_tail [2];
    logic       prog_clk [2];
    logic       set_cfg [2];
    logic [7:0] tail_byte [2];
    logic       tail_valid [2];
    logic       busy [2];
    logic       done [2];
    logic       mismatch [2];
    logic [4:0] mc0;
    logic [3:0] mc1;

    // Chain models and monitor state (written only by the monitor block)
    logic [15:0] chain [2]     = '{16'h0, 16'h0};
    logic [63:0] head_acc [2]  = '{64'h0, 64'h0};
    logic [63:0] tail_acc [2]  = '{64'h0, 64'h0};
    int          edges [2]     = '{0, 0};
    int          tail_n [2]    = '{0, 0};
    int          bad [2]       = '{0, 0};
    int          hi_run [2]    = '{0, 0};
    int          lo_run [2]    = '{100, 100};
    logic        pc_prev [2]   = '{1'b0, 1'b0};

    // Bench-side reference state
    logic        tie0 [2];
    logic [15:0] prev [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign ccff_tail[0] = tie0[0] ? 1'b0 : chain[0][15];
    assign ccff_tail[1] = tie0[1] ? 1'b0 : chain[1][11];

    ccff_bitstream_loader #(
        .CHAIN_LEN (16),
        .DIV       (1)
    ) dut0 (
        .clk          (clk),
        .reset        (reset),
        .start        (start[0]),
        .verify       (verify[0]),
        .byte_in      (byte_in[0]),
        .byte_valid   (byte_valid[0]),
        .byte_ready   (byte_ready[0]),
        .ccff_head    (ccff_head[0]),
        .ccff_tail    (ccff_tail[0]),
        .prog_clk     (prog_clk[0]),
        .set_cfg      (set_cfg[0]),
        .tail_byte    (tail_byte[0]),
        .tail_valid   (tail_valid[0]),
        .busy         (busy[0]),
        .done         (done[0]),
        .mismatch     (mismatch[0]),
        .mismatch_cnt (mc0)
    );

    ccff_bitstream_loader #(
        .CHAIN_LEN (12),
        .DIV       (2)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (start[1]),
        .verify       (verify[1]),
        .byte_in      (byte_in[1]),
        .byte_valid   (byte_valid[1]),
        .byte_ready   (byte_ready[1]),
        .ccff_head    (ccff_head[1]),
        .ccff_tail    (ccff_tail[1]),
        .prog_clk     (prog_clk[1]),
        .set_cfg      (set_cfg[1]),
        .tail_byte    (tail_byte[1]),
        .tail_valid   (tail_valid[1]),
        .busy         (busy[1]),
        .done         (done[1]),
        .mismatch     (mismatch[1]),
        .mismatch_cnt (mc1)
    );

    // Chain shifting, head capture, pulse-shape and tail_valid monitoring
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (prog_clk[k] && !pc_prev[k]) begin
                edges[k]    <= edges[k] + 1;
                head_acc[k] <= {head_acc[k][62:0], ccff_head[k]};
                chain[k]    <= {chain[k][14:0], ccff_head[k]};
                if (lo_run[k] < k + 1) bad[k] <= bad[k] + 1;
                hi_run[k]   <= 1;
            end else if (prog_clk[k]) begin
                hi_run[k] <= hi_run[k] + 1;
            end else if (pc_prev[k]) begin
                if (hi_run[k] != k + 1) bad[k] <= bad[k] + 1;
                lo_run[k] <= 1;
            end else begin
                lo_run[k] <= lo_run[k] + 1;
            end
            if (tail_valid[k]) begin
                tail_acc[k] <= {tail_acc[k][55:0], tail_byte[k]};
                tail_n[k]   <= tail_n[k] + 1;
            end
            pc_prev[k] <= prog_clk[k];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int get_mc(input int k);
        return (k == 0) ? int'(mc0) : int'(mc1);
    endfunction

    // One full two-byte load; expectations come from the chain contents left by the last load
    task automatic run_load(input int k, input bit vfy, input logic [7:0] b0,
                            input logic [7:0] b1, input bit stall, input bit tie);
        int          len;
        logic [15:0] cur;
        logic [15:0] mask;
        logic [15:0] exp_tail;
        int          mis_exp;
        int          e0, t0, bw0, n, stall_bad;
        len      = (k == 0) ? 16 : 12;
        mask     = 16'hFFFF >> (16 - len);
        cur      = {b0, b1} >> (16 - len);
        exp_tail = tie ? 16'h0 : (prev[k] << (16 - len));
        mis_exp  = vfy ? $countones((prev[k] ^ cur) & mask) : 0;
        tie0[k]  = tie;
        @(negedge clk);
        e0  = edges[k];
        t0  = tail_n[k];
        bw0 = bad[k];
        start[k]  = 1'b1;
        verify[k] = vfy;
        @(negedge clk);
        start[k]  = 1'b0;
        verify[k] = 1'b0;
        chk("ready_after_start", byte_ready[k], 1);
        chk("busy_after_start", busy[k], 1);
        chk("done_cleared", done[k], 0);
        for (int b = 0; b < 2; b++) begin
            if (b == 1 && stall) begin
                n = 0;
                while (byte_ready[k] !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                stall_bad = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (prog_clk[k] !== 1'b0 || byte_ready[k] !== 1'b1) stall_bad++;
                end
                chk("stall_hold", stall_bad, 0);
            end
            byte_in[k]    = (b == 0) ? b0 : b1;
            byte_valid[k] = 1'b1;
            n = 0;
            while (byte_ready[k] !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("byte_accept_wait", byte_ready[k], 1);
            @(negedge clk);
            byte_valid[k] = 1'b0;
            byte_in[k]    = 8'($urandom);
            if (b == 0) begin
                // Start while busy must be ignored
                start[k] = 1'b1;
                @(negedge clk);
                start[k] = 1'b0;
            end
        end
        chk("ready_drop", byte_ready[k], 0);
        n = 0;
        while (done[k] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done_set", done[k], 1);
        chk("busy_end", busy[k], 0);
        @(negedge clk);
        chk("prog_clk_edges", edges[k] - e0, len);
        chk("head_sequence", head_acc[k][15:0] & mask, cur);
        chk("pulse_shape", bad[k] - bw0, 0);
        chk("tail_pulses", tail_n[k] - t0, 2);
        chk("tail_bytes", tail_acc[k][15:0], exp_tail);
        chk("mismatch_flag", mismatch[k], (mis_exp != 0) ? 1 : 0);
        chk("mismatch_cnt", get_mc(k), mis_exp);
        prev[k] = cur;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k]      = 1'b0;
            verify[k]     = 1'b0;
            byte_in[k]    = 8'h00;
            byte_valid[k] = 1'b0;
            tie0[k]       = 1'b0;
            prev[k]       = 16'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_prog_clk", prog_clk[k], 0);
            chk("rst_head", ccff_head[k], 0);
            chk("rst_ready", byte_ready[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_done", done[k], 0);
            chk("rst_mismatch", mismatch[k], 0);
            chk("rst_mis_cnt", get_mc(k), 0);
            chk("rst_tail_byte", tail_byte[k], 0);
            chk("rst_tail_valid", tail_valid[k], 0);
            chk("set_cfg_tied", set_cfg[k], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Plain load with tail tied low
        run_load(0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1);
        // Chain readback, then verified reload of the same stream
        run_load(0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0);
        run_load(0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0);
        // Verified reload with one flipped bit
        run_load(0, 1'b1, 8'hA4, 8'h3C, 1'b0, 1'b0);
        // Partial final byte on the 12-flop chain
        run_load(1, 1'b0, 8'hFF, 8'hF0, 1'b0, 1'b0);
        run_load(1, 1'b1, 8'hFF, 8'hF0, 1'b0, 1'b0);
        // Byte stall mid-load
        run_load(0, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        run_load(1, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);

        // Reset while prog_clk is high
        tie0[0]       = 1'b1;
        start[0]      = 1'b1;
        @(negedge clk);
        start[0]      = 1'b0;
        byte_in[0]    = 8'h5A;
        byte_valid[0] = 1'b1;
        @(negedge clk);
        byte_valid[0] = 1'b0;
        n = 0;
        while (prog_clk[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_shift_hi", prog_clk[0], 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_prog_clk", prog_clk[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_done", done[0], 0);
        chk("abort_ready", byte_ready[0], 0);
        reset = 1'b0;
        run_load(0, 1'b0, 8'h96, 8'hE1, 1'b0, 1'b1);
        run_load(0, 1'b1, 8'h96, 8'hE1, 1'b0, 1'b0);

        // Randomized loads on both chains
        repeat (8) begin
            run_load(int'($urandom_range(1, 0)), 1'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
